cpu_io_port: RTL and testbench
==============================

CPU_IO_PORT -- requirements
Module: cpu_io_port

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
REQ-002 Parameter: DEBOUNCE_CYCLES, 16, stable cycles required on trap_btn; used only with debounce compiled in.
REQ-003 The module SHALL have one clock (clk) and an asynchronous, active-low reset (async_nreset); polarity and synchronicity are fixed.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: async_nreset  input  1  asynchronous active-low reset.
REQ-006 Port: cpu_io_write  input  1  CPU OUT strobe, one cycle per OUT instruction.
REQ-007 Port: cpu_io_data  input  8  CPU accumulator value for OUT.
REQ-008 Port: cpu_io_rdata  output  8  value the CPU samples on IN.
REQ-009 Port: cpu_exit_trap  output  1  one-cycle pulse releasing CPU from TRAP.
REQ-010 Port: out_data  output  8  head of output FIFO.
REQ-011 Port: out_valid  output  1  FIFO non-empty.
REQ-012 Port: out_ready  input  1  sink accepts out_data.
REQ-013 Port: in_data  input  8  external input byte.
REQ-014 Port: in_valid  input  1  in_data valid this cycle.
REQ-015 Port: trap_btn  input  1  raw asynchronous button level.
REQ-016 Port: overflow  output  1  sticky: an OUT write was dropped.
REQ-017 Port: fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-018 Push occurs on cpu_io_write when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
REQ-019 Pop occurs when out_valid && out_ready.
REQ-020 Pushed byte SHALL appear on out_data/out_valid the cycle after the write when the FIFO was empty (1-cycle latency); no bypass path.
REQ-021 Order SHALL be strict FIFO; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 Simultaneous push and pop at any occupancy SHALL leave count unchanged.
REQ-023 Push while full without pop SHALL drop the byte, leave the FIFO unchanged, and set overflow until reset.
REQ-024 out_data SHALL hold stable while out_valid && !out_ready.
REQ-025 An in_data byte with in_valid high SHALL be registered into the holding register and appear on cpu_io_rdata the next cycle; with no in_valid the last value is held.
REQ-026 trap_btn SHALL pass through a 2-flop synchronizer; a rising edge of the filtered level SHALL produce exactly one cycle of cpu_exit_trap.
REQ-027 A held button SHALL NOT retrigger; a new pulse requires release then press.

Reset
REQ-028 On async_nreset low: FIFO empty, pointers 0, out_valid 0, out_data 0, cpu_io_rdata 0, overflow 0, cpu_exit_trap 0, synchronizer, edge and debounce state 0.
REQ-029 Reset mid-transfer SHALL discard FIFO contents; the first post-reset write SHALL be entry 0.

Configuration
REQ-030 Macro CPU_IO_PORT_DEBOUNCE_EN defined: filtered level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter resets on any mismatch glitch.
REQ-031 Macro CPU_IO_PORT_DEBOUNCE_EN undefined: filtered level is the synchronizer output, so cpu_exit_trap is high in the 3rd cycle after trap_btn is first sampled high.

Structure
REQ-032 Shared package cpu_io_pkg SHALL hold DATA_WIDTH=8, default FIFO_DEPTH, and default DEBOUNCE_CYCLES.
REQ-033 The FIFO SHALL be a sub-module io_fifo (push/pop/full/empty/count); synchronizer, debounce and edge logic SHALL stay in cpu_io_port.

Verification
REQ-034 Scenario: write 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first write; count returns to 0.
REQ-035 Scenario: out_ready=0, write 5 bytes 0x01..0x05 at depth 4 -> count=4, overflow=1; then out_ready=1 -> 0x01..0x04 drained, 0x05 never appears.
REQ-036 Scenario: full FIFO, cpu_io_write=1 (0xAA) with out_ready=1 in the same cycle -> overflow stays 0, count stays 4, 0xAA is delivered last.
REQ-037 Scenario: in_valid pulse with in_data=0x5C -> cpu_io_rdata=0x5C next cycle and held after in_valid drops.
REQ-038 Scenario: trap_btn high for 40 cycles, DEBOUNCE_CYCLES=16, macro defined -> exactly one cpu_exit_trap pulse; a 10-cycle glitch produces none; macro undefined -> a pulse in the 3rd cycle.
REQ-039 Scenario: assert async_nreset low mid-drain with count=3 -> all outputs 0 immediately; after release, writing 0x77 yields out_data=0x77.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared types and defaults for the CPU I/O port and its output FIFO.
package cpu_io_pkg;

  localparam int DATA_WIDTH              = 8;
  localparam int FIFO_DEPTH_DEFAULT      = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int COUNT_WIDTH             = 5;

  // Encoded so {push, pop} maps straight onto the enum value.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  typedef enum logic [1:0] {
    TRAP_IDLE,
    TRAP_PULSE,
    TRAP_HELD
  } trap_state_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Output FIFO for CPU OUT bytes; head is visible one cycle after the push.
module io_fifo
  import cpu_io_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == COUNT_WIDTH'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case (fifo_op(w_do_push, w_do_pop))
        FIFO_PUSH: r_count <= r_count + COUNT_WIDTH'(1);
        FIFO_POP:  r_count <= r_count - COUNT_WIDTH'(1);
        default:   r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_io_port.sv
// CPU I/O port: OUT byte FIFO, IN holding register and TRAP-release button.
// Define CPU_IO_PORT_DEBOUNCE_EN to add a DEBOUNCE_CYCLES filter on trap_btn.
module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   async_nreset,
  input  logic                   cpu_io_write,
  input  logic [DATA_WIDTH-1:0]  cpu_io_data,
  output logic [DATA_WIDTH-1:0]  cpu_io_rdata,
  output logic                   cpu_exit_trap,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   trap_btn,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] fifo_count
);

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_filt;
  logic [DATA_WIDTH-1:0] r_in_hold;
  logic                  r_overflow;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_exit_trap;
  trap_state_e           r_trap_state;

  assign out_valid     = !w_empty;
  assign w_pop         = out_valid && out_ready;
  assign cpu_io_rdata  = r_in_hold;
  assign overflow      = r_overflow;
  assign cpu_exit_trap = r_exit_trap;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (async_nreset),
    .i_push  (cpu_io_write),
    .i_wdata (cpu_io_data),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_in_hold  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        r_in_hold <= in_data;
      end
      if (cpu_io_write && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= trap_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CPU_IO_PORT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_filt;

  // The filtered level only follows the synchronizer after an unbroken run of disagreement.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt <= '0;
      r_filt   <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  // HELD blocks retriggering until the filtered button is released.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_trap_state <= TRAP_IDLE;
      r_exit_trap  <= 1'b0;
    end else begin
      r_exit_trap <= 1'b0;
      case (r_trap_state)
        TRAP_IDLE: begin
          if (w_filt) begin
            r_trap_state <= TRAP_PULSE;
            r_exit_trap  <= 1'b1;
          end
        end
        TRAP_PULSE: r_trap_state <= w_filt ? TRAP_HELD : TRAP_IDLE;
        TRAP_HELD: begin
          if (!w_filt) begin
            r_trap_state <= TRAP_IDLE;
          end
        end
        default: r_trap_state <= TRAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed vector bench for cpu_io_port: FIFO, IN register, reset and trap button.
module tb_cpu_io_port;

  logic       clk;
  logic       async_nreset;
  logic       cpu_io_write;
  logic [7:0] cpu_io_data;
  logic [7:0] cpu_io_rdata;
  logic       cpu_exit_trap;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       trap_btn;
  logic       overflow;
  logic [4:0] fifo_count;

  int vecCount  = 0;
  int missCount = 0;

  cpu_io_port #(
    .FIFO_DEPTH      (4),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk           (clk),
    .async_nreset  (async_nreset),
    .cpu_io_write  (cpu_io_write),
    .cpu_io_data   (cpu_io_data),
    .cpu_io_rdata  (cpu_io_rdata),
    .cpu_exit_trap (cpu_exit_trap),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .trap_btn      (trap_btn),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstN;
    logic       wr;
    logic [7:0] wdata;
    logic       rdy;
    logic       inValid;
    logic [7:0] inData;
    logic       expValid;
    logic [7:0] expData;
    logic [4:0] expCount;
    logic       expOvf;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mkVec(input logic rstN, input logic wr, input logic [7:0] wdata,
                                 input logic rdy, input logic inValid, input logic [7:0] inData,
                                 input logic expValid, input logic [7:0] expData,
                                 input logic [4:0] expCount, input logic expOvf,
                                 input logic [7:0] expRdata);
    vec_t v;
    v.rstN = rstN; v.wr = wr; v.wdata = wdata; v.rdy = rdy;
    v.inValid = inValid; v.inData = inData;
    v.expValid = expValid; v.expData = expData; v.expCount = expCount;
    v.expOvf = expOvf; v.expRdata = expRdata;
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    async_nreset = v.rstN;
    cpu_io_write = v.wr;
    cpu_io_data  = v.wdata;
    out_ready    = v.rdy;
    in_valid     = v.inValid;
    in_data      = v.inData;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic countPulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      stepCycle();
      if (cpu_exit_trap === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;

    // Basic streaming, IN register, overflow drain, full push-with-pop, wrap.
    vecs[0]  = mkVec(1, 1, 8'h11, 1, 0, 8'h00, 1, 8'h11, 1, 0, 8'h00);
    vecs[1]  = mkVec(1, 1, 8'h22, 1, 0, 8'h00, 1, 8'h22, 1, 0, 8'h00);
    vecs[2]  = mkVec(1, 1, 8'h33, 1, 0, 8'h00, 1, 8'h33, 1, 0, 8'h00);
    vecs[3]  = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    vecs[4]  = mkVec(1, 0, 8'h00, 0, 1, 8'h5C, 0, 8'h00, 0, 0, 8'h5C);
    vecs[5]  = mkVec(1, 0, 8'h00, 0, 0, 8'hAA, 0, 8'h00, 0, 0, 8'h5C);
    vecs[6]  = mkVec(1, 1, 8'h01, 0, 0, 8'h00, 1, 8'h01, 1, 0, 8'h5C);
    vecs[7]  = mkVec(1, 1, 8'h02, 0, 0, 8'h00, 1, 8'h01, 2, 0, 8'h5C);
    vecs[8]  = mkVec(1, 1, 8'h03, 0, 0, 8'h00, 1, 8'h01, 3, 0, 8'h5C);
    vecs[9]  = mkVec(1, 1, 8'h04, 0, 0, 8'h00, 1, 8'h01, 4, 0, 8'h5C);
    vecs[10] = mkVec(1, 1, 8'h05, 0, 0, 8'h00, 1, 8'h01, 4, 1, 8'h5C);
    vecs[11] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h02, 3, 1, 8'h5C);
    vecs[12] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h03, 2, 1, 8'h5C);
    vecs[13] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h04, 1, 1, 8'h5C);
    vecs[14] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h5C);
    vecs[15] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
    vecs[16] = mkVec(1, 1, 8'h41, 0, 0, 8'h00, 1, 8'h41, 1, 0, 8'h00);
    vecs[17] = mkVec(1, 1, 8'h42, 0, 0, 8'h00, 1, 8'h41, 2, 0, 8'h00);
    vecs[18] = mkVec(1, 1, 8'h43, 0, 0, 8'h00, 1, 8'h41, 3, 0, 8'h00);
    vecs[19] = mkVec(1, 1, 8'h44, 0, 0, 8'h00, 1, 8'h41, 4, 0, 8'h00);
    vecs[20] = mkVec(1, 1, 8'hAA, 1, 0, 8'h00, 1, 8'h42, 4, 0, 8'h00);
    vecs[21] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h43, 3, 0, 8'h00);
    vecs[22] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'h44, 2, 0, 8'h00);
    vecs[23] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 1, 8'hAA, 1, 0, 8'h00);
    vecs[24] = mkVec(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);

    async_nreset = 1'b1;
    cpu_io_write = 1'b0;
    cpu_io_data  = 8'h00;
    out_ready    = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    trap_btn     = 1'b0;
    #2 async_nreset = 1'b0;
    repeat (2) stepCycle();

    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'h00);
    checkOutput("reset fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset cpu_io_rdata", 32'(cpu_io_rdata), 32'h00);
    checkOutput("reset cpu_exit_trap", 32'(cpu_exit_trap), 32'd0);
    async_nreset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
      if (vecs[i].expValid)
        checkOutput($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].expData));
      checkOutput($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].expCount));
      checkOutput($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
      checkOutput($sformatf("v%0d cpu_io_rdata", i), 32'(cpu_io_rdata), 32'(vecs[i].expRdata));
      checkOutput($sformatf("v%0d cpu_exit_trap", i), 32'(cpu_exit_trap), 32'd0);
    end

    // Reset mid-drain with three entries left, then confirm the first write lands at the head.
    applyStimulus(mkVec(1, 1, 8'h61, 0, 1, 8'h3C, 0, 0, 0, 0, 0));
    stepCycle();
    in_valid = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      cpu_io_data = 8'h60 + 8'(b);
      stepCycle();
    end
    cpu_io_write = 1'b0;
    out_ready    = 1'b1;
    stepCycle();
    checkOutput("drain count before reset", 32'(fifo_count), 32'd3);
    checkOutput("drain head before reset", 32'(out_data), 32'h62);
    checkOutput("rdata before reset", 32'(cpu_io_rdata), 32'h3C);
    #2 async_nreset = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_data", 32'(out_data), 32'h00);
    checkOutput("midreset fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("midreset cpu_io_rdata", 32'(cpu_io_rdata), 32'h00);
    checkOutput("midreset overflow", 32'(overflow), 32'd0);
    stepCycle();
    applyStimulus(mkVec(1, 1, 8'h77, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    stepCycle();
    cpu_io_write = 1'b0;
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd1);
    checkOutput("post-reset out_data", 32'(out_data), 32'h77);
    checkOutput("post-reset fifo_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("post-reset drained", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;

`ifdef CPU_IO_PORT_DEBOUNCE_EN
    trap_btn = 1'b1;
    countPulses(40, pulses);
    checkOutput("debounce press pulses", 32'(pulses), 32'd1);
    trap_btn = 1'b0;
    countPulses(30, pulses);
    checkOutput("debounce release pulses", 32'(pulses), 32'd0);
    trap_btn = 1'b1;
    repeat (10) stepCycle();
    trap_btn = 1'b0;
    countPulses(30, pulses);
    checkOutput("debounce glitch pulses", 32'(pulses), 32'd0);
    trap_btn = 1'b1;
    countPulses(40, pulses);
    checkOutput("debounce repress pulses", 32'(pulses), 32'd1);
    trap_btn = 1'b0;
    repeat (30) stepCycle();
`else
    trap_btn = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      stepCycle();
      checkOutput($sformatf("trap cycle %0d", c), 32'(cpu_exit_trap), 32'(c == 3));
    end
    countPulses(37, pulses);
    checkOutput("trap held no retrigger", 32'(pulses), 32'd0);
    trap_btn = 1'b0;
    countPulses(10, pulses);
    checkOutput("trap release pulses", 32'(pulses), 32'd0);
    trap_btn = 1'b1;
    countPulses(10, pulses);
    checkOutput("trap repress pulses", 32'(pulses), 32'd1);
    trap_btn = 1'b0;
    repeat (5) stepCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
